// File: rtl/fpmul_pkg.sv
// Shared constants and types for the FP multiplier product normalizer.
package fpmul_pkg;
    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Normalized mantissa plus round bits, carried from stage 2 into stage 3.
    typedef struct packed {
        logic [MAN_W:0] mant;
        logic           g;
        logic           st;
        logic [9:0]     e;
        logic           sign;
        logic           zero;
    } s2_t;
endpackage

// File: rtl/fpmul_product_normalizer_rne_round.sv
// Round-to-nearest-even on a normalized 24-bit mantissa; mantissa carry bumps the exponent.
module rne_round
    import fpmul_pkg::*;
(
    input  logic [MAN_W:0]   mant,
    input  logic             g,
    input  logic             st,
    input  logic [9:0]       e,
    output logic [MAN_W-1:0] frac,
    output logic [9:0]       e_adj
);
    logic             up;
    logic             carry;
    logic             hidden;
    logic [MAN_W-1:0] rounded;

    assign up = g & (st | mant[0]);
    assign {carry, hidden, rounded} = {1'b0, mant} + {{(MAN_W+1){1'b0}}, up};

    // The hidden bit only drops to 0 on a carry-out, where the fraction must read 0.
    assign frac  = hidden ? rounded : '0;
    assign e_adj = e + {9'd0, carry};
endmodule

// File: rtl/fpmul_product_normalizer.sv
// Final FP multiply stage: sums partial products, normalizes, rounds RNE and packs IEEE single.
module fpmul_product_normalizer
    import fpmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] hh,
    input  logic [63:0] mid,
    input  logic [31:0] ll,
    input  logic        sign_in,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic        zero_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf
);
    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    // Each stage may load when it is empty or its content moves on this cycle.
    assign ld3       = !v3 | out_ready;
    assign ld2       = !v2 | ld3;
    assign ld1       = !v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // ---------------- stage 1: product assembly ----------------
    logic [63:0] psum;
    logic [9:0]  e_raw;
    logic [61:0] p1;
    logic [9:0]  e1;
    logic        sign1, zero1;

    assign psum  = {hh, 32'd0} + {mid[47:0], 16'd0} + {32'd0, ll};
    assign e_raw = {2'b00, exp_a} + {2'b00, exp_b} - 10'(BIAS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            p1    <= '0;
            e1    <= '0;
            sign1 <= 1'b0;
            zero1 <= 1'b0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p1    <= psum[61:0];
                e1    <= e_raw;
                sign1 <= sign_in;
                zero1 <= zero_in;
            end
        end
    end

    // ---------------- stage 2: normalize ----------------
    s2_t s2_d, r2;

    always_comb begin
        s2_d      = '0;
        s2_d.sign = sign1;
        s2_d.zero = zero1;
        if (p1[61]) begin
            s2_d.mant = p1[61:38];
            s2_d.g    = p1[37];
            s2_d.st   = |p1[36:0];
            s2_d.e    = e1 + 10'd1;
        end else begin
            s2_d.mant = p1[60:37];
            s2_d.g    = p1[36];
            s2_d.st   = |p1[35:0];
            s2_d.e    = e1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            r2 <= '0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1)
                r2 <= s2_d;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic [MAN_W-1:0] rfrac;
    logic [9:0]       radj;
    fp32_t            pk;
    logic             ovf_d, unf_d;

    rne_round u_rnd (
        .mant  (r2.mant),
        .g     (r2.g),
        .st    (r2.st),
        .e     (r2.e),
        .frac  (rfrac),
        .e_adj (radj)
    );

    always_comb begin
        pk      = '0;
        pk.sign = r2.sign;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (r2.zero) begin
            pk.exp = '0;
        end else if ($signed(radj) >= 10'sd255) begin
            pk.exp = '1;
            ovf_d  = 1'b1;
        end else if ($signed(radj) <= 10'sd0) begin
            unf_d  = 1'b1;
        end else begin
            pk.exp  = radj[EXP_W-1:0];
            pk.frac = rfrac;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3     <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (ld3) begin
            v3 <= v2;
            if (v2) begin
                result <= pk;
                ovf    <= ovf_d;
                unf    <= unf_d;
            end
        end
    end
endmodule

// File: tb/tb_fpmul_product_normalizer.sv
// Self-checking bench: directed IEEE cases plus randomized streams against a rounding model.
module tb_fpmul_product_normalizer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] hh, ll, result;
    logic [63:0] mid;
    logic        sign_in, zero_in, ovf, unf;
    logic [7:0]  exp_a, exp_b;

    fpmul_product_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .hh(hh), .mid(mid), .ll(ll), .sign_in(sign_in),
        .exp_a(exp_a), .exp_b(exp_b), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t q[$];
    exp_t nxt;
    int   checks = 0;
    int   errors = 0;
    bit   stall_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: exact product, divide down to 24 bits, RNE on the discarded remainder.
    function automatic exp_t model(input logic [31:0] h, input logic [63:0] m, input logic [31:0] l,
                                   input logic s, input logic [7:0] ea, input logic [7:0] eb,
                                   input logic z);
        logic [63:0] p, rem, half, mant;
        int          sh, e;
        exp_t        r;
        p    = (({32'd0, h} << 32) + (m << 16) + {32'd0, l}) & 64'h3FFF_FFFF_FFFF_FFFF;
        sh   = p[61] ? 38 : 37;
        e    = int'(ea) + int'(eb) - 127 + (p[61] ? 1 : 0);
        mant = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (z) r.res = {s, 31'd0};
        else if (e >= 255) begin r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; end
        else if (e <= 0) begin r.res = {s, 31'd0}; r.unf = 1'b1; end
        else r.res = {s, 8'(e), mant[22:0]};
        return r;
    endfunction

    task automatic set_in(input logic [31:0] h, input logic [63:0] m, input logic [31:0] l,
                          input logic s, input logic [7:0] ea, input logic [7:0] eb,
                          input logic z, input exp_t ex);
        hh = h; mid = m; ll = l; sign_in = s; exp_a = ea; exp_b = eb; zero_in = z; nxt = ex;
    endtask

    function automatic logic [7:0] rand_exp();
        case ($urandom % 8)
            0:       return 8'($urandom_range(200, 254));
            1:       return 8'($urandom_range(1, 40));
            default: return 8'($urandom_range(60, 190));
        endcase
    endfunction

    task automatic set_rand();
        logic [63:0] a, b, c, d, m;
        logic [7:0]  ea, eb;
        logic        s, z;
        a  = 64'($urandom_range(16384, 32767));
        c  = 64'($urandom_range(16384, 32767));
        b  = 64'($urandom_range(0, 65535));
        d  = 64'($urandom_range(0, 65535));
        m  = a * d + c * b;
        ea = rand_exp();
        eb = rand_exp();
        s  = 1'($urandom);
        z  = ($urandom % 16) == 0;
        set_in(32'(a * c), m, 32'(b * d), s, ea, eb, z,
               model(32'(a * c), m, 32'(b * d), s, ea, eb, z));
    endtask

    // One cycle: inputs were driven at the falling edge; check, then cross the rising edge.
    task automatic tick(output bit acc);
        #1;
        chk("in_ready", in_ready, !(q.size() == 3 && !out_ready));
        if (in_valid && !in_ready) stall_seen = 1'b1;
        if (out_valid) begin
            chk("no_spurious_valid", q.size() != 0, 1);
            if (q.size() != 0) begin
                chk("result", result, q[0].res);
                chk("ovf", ovf, q[0].ovf);
                chk("unf", unf, q[0].unf);
                if (out_ready) void'(q.pop_front());
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(nxt);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit acc, need;
        int lat, idx;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, '0);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {ovf, unf}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // 1.0 * 1.0 with latency measurement
        set_in(32'h1000_0000, 0, 0, 0, 127, 127, 0, '{32'h3F80_0000, 1'b0, 1'b0});
        in_valid = 1'b1;
        tick(acc);
        chk("accept_1p0", acc, 1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick(acc);
            lat++;
        end
        chk("latency", lat, 3);

        // directed vectors streamed back to back
        in_valid = 1'b1;
        set_in(32'h2400_0000, 0, 0, 0, 127, 127, 0, '{32'h4010_0000, 1'b0, 1'b0}); tick(acc);
        set_in(32'h1000_0000, 0, 0, 1, 254, 254, 0, '{32'hFF80_0000, 1'b1, 1'b0}); tick(acc);
        set_in(32'h1000_0000, 0, 0, 0, 1, 1, 0, '{32'h0000_0000, 1'b0, 1'b1}); tick(acc);
        set_in(32'h1FFF_FFF0, 0, 0, 0, 127, 127, 0, '{32'h4000_0000, 1'b0, 1'b0}); tick(acc);
        set_in(32'h1000_0010, 0, 0, 0, 127, 127, 0, '{32'h3F80_0000, 1'b0, 1'b0}); tick(acc);
        set_in(32'h1000_0030, 0, 0, 0, 127, 127, 0, '{32'h3F80_0002, 1'b0, 1'b0}); tick(acc);
        set_in(32'h1000_0000, 0, 0, 1, 254, 254, 1, '{32'h8000_0000, 1'b0, 1'b0}); tick(acc);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick(acc);
        chk("directed_drained", q.size(), 0);

        // backpressure: 5 vectors, consumer stalled on cycles 2..8
        stall_seen = 1'b0;
        idx = 0;
        need = 1'b1;
        for (int c = 0; c < 40 && (idx < 5 || q.size() > 0); c++) begin
            out_ready = !(c >= 2 && c <= 8);
            if (idx < 5 && need) begin set_rand(); need = 1'b0; end
            in_valid = idx < 5;
            tick(acc);
            if (acc) begin idx++; need = 1'b1; end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_seen", stall_seen, 1);
        chk("bp_all_accepted", idx, 5);
        chk("bp_drained", q.size(), 0);

        // reset during a 3-deep burst discards everything in flight
        in_valid = 1'b1;
        set_rand(); tick(acc);
        set_rand(); tick(acc);
        set_rand();
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_no_valid", out_valid, 0);
            tick(acc);
        end

        // randomized traffic with random backpressure
        need = 1'b1;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom % 4) != 0;
            if (need) begin set_rand(); need = 1'b0; end
            in_valid = ($urandom % 4) != 0;
            tick(acc);
            if (acc) need = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) tick(acc);
        chk("final_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
